// File: rtl/usb_rx_packet_fifo.sv
// usb_rx_packet_fifo
//   Packet-aware receive FIFO placed after the USB receive top level. Each
//   incoming packet is written speculatively. It becomes visible to the
//   reader only when its last byte arrives with no error. A receive error
//   rolls the packet back. A packet that does not fit is dropped and
//   reported through the overflow pulse.
//
// Ports
//   clk, n_rst         system clock (rising edge), async active-low reset
//   packet_type        selects expected packet length (0: PKT0_LEN, 1: PKT1_LEN)
//   rx_data            received byte, valid while write_enable=1
//   write_enable       one-cycle strobe per received byte
//   rcv_error          current packet is invalid; discard it
//   read_enable        pop one committed byte
//   read_data          byte at the committed head (show-ahead)
//   empty / full       no committed bytes / storage holds DEPTH bytes
//   rd_count           committed unread bytes
//   pkt_done           one-cycle pulse when a packet commits
//   overflow           one-cycle pulse when a packet is dropped for lack of space
//
// state     | meaning
// ----------+---------------------------------------------------
// S_IDLE    | waiting for the first byte of a packet
// S_COLLECT | storing bytes of the current packet
// S_DROP    | discarding the rest of a packet that did not fit
module usb_rx_packet_fifo #(
    parameter int DEPTH    = 16,
    parameter int PKT0_LEN = 3,
    parameter int PKT1_LEN = 7
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     packet_type,
    input  logic [7:0]               rx_data,
    input  logic                     write_enable,
    input  logic                     rcv_error,
    input  logic                     read_enable,
    output logic [7:0]               read_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   rd_count,
    output logic                     pkt_done,
    output logic                     overflow
);

    localparam int            AW   = $clog2(DEPTH);
    localparam int            PW   = AW + 1;
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [7:0]    LEN0 = 8'(PKT0_LEN);
    localparam logic [7:0]    LEN1 = 8'(PKT1_LEN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DROP    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [PW-1:0] cw_q, cw_d;
    logic [PW-1:0] sw_q, sw_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    len_q, len_d;
    logic          pkt_done_q, pkt_done_d;
    logic          overflow_q, overflow_d;
    logic          mem_we;
    logic [7:0]    pkt_len;
    logic [7:0]    cnt_inc;
    logic [7:0]    mem_q [DEPTH];

    // Occupancy counts speculative bytes too, so a packet in flight
    // reserves its space against later writes.
    assign empty     = (rp_q == cw_q);
    assign full      = ((sw_q - rp_q) == PW'(DEPTH));
    assign rd_count  = cw_q - rp_q;
    assign read_data = mem_q[rp_q[AW-1:0]];
    assign pkt_done  = pkt_done_q;
    assign overflow  = overflow_q;

    assign pkt_len = packet_type ? LEN1 : LEN0;
    assign cnt_inc = byte_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            rp_q       <= '0;
            cw_q       <= '0;
            sw_q       <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            pkt_done_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rp_q       <= rp_d;
            cw_q       <= cw_d;
            sw_q       <= sw_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            pkt_done_q <= pkt_done_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[sw_q[AW-1:0]] <= rx_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        rp_d       = rp_q;
        cw_d       = cw_q;
        sw_d       = sw_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        pkt_done_d = 1'b0;
        overflow_d = 1'b0;
        mem_we     = 1'b0;

        // The read side is independent of the packet state machine.
        if (read_enable && !empty) begin
            rp_d = rp_q + ONE;
        end

        if (rcv_error) begin
            // Error wins over a byte arriving in the same cycle.
            sw_d       = cw_q;
            byte_cnt_d = '0;
            state_d    = S_IDLE;
        end else if (write_enable) begin
            unique case (state_q)
                S_IDLE: begin
                    len_d = pkt_len;
                    if (!full) begin
                        mem_we = 1'b1;
                        sw_d   = sw_q + ONE;
                        if (pkt_len == 8'd1) begin
                            cw_d       = sw_q + ONE;
                            pkt_done_d = 1'b1;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = 8'd1;
                            state_d    = S_COLLECT;
                        end
                    end else begin
                        overflow_d = 1'b1;
                        if (pkt_len == 8'd1) begin
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = 8'd1;
                            state_d    = S_DROP;
                        end
                    end
                end
                S_COLLECT: begin
                    if (full) begin
                        // The byte that overflows still counts toward the
                        // packet length so the drop ends on the packet boundary.
                        overflow_d = 1'b1;
                        sw_d       = cw_q;
                        if (cnt_inc == len_q) begin
                            byte_cnt_d = '0;
                            state_d    = S_IDLE;
                        end else begin
                            byte_cnt_d = cnt_inc;
                            state_d    = S_DROP;
                        end
                    end else begin
                        mem_we = 1'b1;
                        sw_d   = sw_q + ONE;
                        if (cnt_inc == len_q) begin
                            cw_d       = sw_q + ONE;
                            pkt_done_d = 1'b1;
                            byte_cnt_d = '0;
                            state_d    = S_IDLE;
                        end else begin
                            byte_cnt_d = cnt_inc;
                        end
                    end
                end
                S_DROP: begin
                    if (cnt_inc == len_q) begin
                        byte_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        byte_cnt_d = cnt_inc;
                    end
                end
                default: begin
                    byte_cnt_d = '0;
                    state_d    = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_packet_fifo.sv
// Directed bench for usb_rx_packet_fifo (DEPTH=16, PKT0_LEN=3, PKT1_LEN=7).
// Inputs change on the falling edge; outputs are checked on the falling
// edge after the rising edge that consumed them.
module tb_usb_rx_packet_fifo;

    logic       clk          = 1'b0;
    logic       n_rst        = 1'b0;
    logic       packet_type  = 1'b0;
    logic [7:0] rx_data      = 8'h00;
    logic       write_enable = 1'b0;
    logic       rcv_error    = 1'b0;
    logic       read_enable  = 1'b0;
    logic [7:0] read_data;
    logic       empty;
    logic       full;
    logic [4:0] rd_count;
    logic       pkt_done;
    logic       overflow;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] p7 [7] = '{8'hC3, 8'h00, 8'h80, 8'h40, 8'hC0, 8'hF7, 8'h5E};

    always #5 clk = ~clk;

    usb_rx_packet_fifo #(
        .DEPTH    (16),
        .PKT0_LEN (3),
        .PKT1_LEN (7)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .packet_type  (packet_type),
        .rx_data      (rx_data),
        .write_enable (write_enable),
        .rcv_error    (rcv_error),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .empty        (empty),
        .full         (full),
        .rd_count     (rd_count),
        .pkt_done     (pkt_done),
        .overflow     (overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns on the next falling edge.
    task automatic cyc(input logic we, input logic [7:0] d, input logic pt,
                       input logic err, input logic re);
        write_enable = we;
        rx_data      = d;
        packet_type  = pt;
        rcv_error    = err;
        read_enable  = re;
        @(negedge clk);
        write_enable = 1'b0;
        rcv_error    = 1'b0;
        read_enable  = 1'b0;
    endtask

    task automatic send_byte(input logic pt, input logic [7:0] d);
        cyc(1'b1, d, pt, 1'b0, 1'b0);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_val(tag, {24'd0, read_data}, {24'd0, exp});
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check_val("in_reset_empty", {31'd0, empty}, 32'd1);
        check_val("in_reset_rd_count", {27'd0, rd_count}, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        check_val("rst_empty", {31'd0, empty}, 32'd1);
        check_val("rst_full", {31'd0, full}, 32'd0);
        check_val("rst_rd_count", {27'd0, rd_count}, 32'd0);
        check_val("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
        check_val("rst_overflow", {31'd0, overflow}, 32'd0);

        // Type-0 packet commit and readback
        send_byte(1'b0, 8'hB4);
        check_val("t0_b1_pkt_done", {31'd0, pkt_done}, 32'd0);
        check_val("t0_b1_rd_count", {27'd0, rd_count}, 32'd0);
        send_byte(1'b0, 8'hA8);
        check_val("t0_b2_rd_count", {27'd0, rd_count}, 32'd0);
        check_val("t0_b2_empty", {31'd0, empty}, 32'd1);
        send_byte(1'b0, 8'hF7);
        check_val("t0_b3_pkt_done", {31'd0, pkt_done}, 32'd1);
        check_val("t0_b3_rd_count", {27'd0, rd_count}, 32'd3);
        check_val("t0_b3_empty", {31'd0, empty}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_val("t0_pkt_done_one_cycle", {31'd0, pkt_done}, 32'd0);
        pop_check("t0_rd0", 8'hB4);
        pop_check("t0_rd1", 8'hA8);
        pop_check("t0_rd2", 8'hF7);
        check_val("t0_drained_empty", {31'd0, empty}, 32'd1);
        check_val("t0_drained_rd_count", {27'd0, rd_count}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("rd_while_empty_count", {27'd0, rd_count}, 32'd0);
        check_val("rd_while_empty_empty", {31'd0, empty}, 32'd1);

        // Type-1 packet aborted by rcv_error, then a clean type-1 packet
        send_byte(1'b1, 8'h11);
        send_byte(1'b1, 8'h22);
        send_byte(1'b1, 8'h33);
        send_byte(1'b1, 8'h44);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check_val("err_rd_count", {27'd0, rd_count}, 32'd0);
        check_val("err_pkt_done", {31'd0, pkt_done}, 32'd0);
        check_val("err_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 7; i++) send_byte(1'b1, p7[i]);
        check_val("t1_pkt_done", {31'd0, pkt_done}, 32'd1);
        check_val("t1_rd_count", {27'd0, rd_count}, 32'd7);
        for (int i = 0; i < 7; i++) pop_check($sformatf("t1_rd%0d", i), p7[i]);
        check_val("t1_drained_empty", {31'd0, empty}, 32'd1);

        // Fill to 14 committed, then a type-0 packet overflows on its 3rd byte
        for (int i = 0; i < 7; i++) send_byte(1'b1, 8'(8'h10 + i));
        for (int i = 0; i < 7; i++) send_byte(1'b1, 8'(8'h20 + i));
        check_val("fill_rd_count", {27'd0, rd_count}, 32'd14);
        check_val("fill_full14", {31'd0, full}, 32'd0);
        send_byte(1'b0, 8'h91);
        check_val("fill_full15", {31'd0, full}, 32'd0);
        send_byte(1'b0, 8'h92);
        check_val("fill_full16", {31'd0, full}, 32'd1);
        check_val("fill_spec_rd_count", {27'd0, rd_count}, 32'd14);
        send_byte(1'b0, 8'h93);
        check_val("ovf_pulse", {31'd0, overflow}, 32'd1);
        check_val("ovf_pkt_done", {31'd0, pkt_done}, 32'd0);
        check_val("ovf_rd_count", {27'd0, rd_count}, 32'd14);
        check_val("ovf_full_after_rollback", {31'd0, full}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_val("ovf_pulse_one_cycle", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 7; i++) pop_check($sformatf("fill_a_rd%0d", i), 8'(8'h10 + i));
        for (int i = 0; i < 7; i++) pop_check($sformatf("fill_b_rd%0d", i), 8'(8'h20 + i));
        check_val("fill_drained_empty", {31'd0, empty}, 32'd1);
        send_byte(1'b0, 8'hA1);
        send_byte(1'b0, 8'hA2);
        send_byte(1'b0, 8'hA3);
        check_val("post_ovf_pkt_done", {31'd0, pkt_done}, 32'd1);
        check_val("post_ovf_rd_count", {27'd0, rd_count}, 32'd3);
        pop_check("post_ovf_rd0", 8'hA1);
        pop_check("post_ovf_rd1", 8'hA2);
        pop_check("post_ovf_rd2", 8'hA3);

        // Wrap-around: ten commit/drain rounds of 3-byte packets
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 3; j++) send_byte(1'b0, 8'(8'h40 + k * 3 + j));
            check_val($sformatf("wrap%0d_pkt_done", k), {31'd0, pkt_done}, 32'd1);
            check_val($sformatf("wrap%0d_rd_count", k), {27'd0, rd_count}, 32'd3);
            check_val($sformatf("wrap%0d_full", k), {31'd0, full}, 32'd0);
            for (int j = 0; j < 3; j++)
                pop_check($sformatf("wrap%0d_rd%0d", k, j), 8'(8'h40 + k * 3 + j));
            check_val($sformatf("wrap%0d_empty", k), {31'd0, empty}, 32'd1);
        end

        // Error together with the final byte: nothing commits
        send_byte(1'b0, 8'hD1);
        send_byte(1'b0, 8'hD2);
        cyc(1'b1, 8'hD3, 1'b0, 1'b1, 1'b0);
        check_val("err_last_rd_count", {27'd0, rd_count}, 32'd0);
        check_val("err_last_pkt_done", {31'd0, pkt_done}, 32'd0);
        send_byte(1'b0, 8'hE1);
        send_byte(1'b0, 8'hE2);
        send_byte(1'b0, 8'hE3);
        check_val("after_err_rd_count", {27'd0, rd_count}, 32'd3);

        // Read on the same cycle as a commit
        send_byte(1'b0, 8'hF1);
        send_byte(1'b0, 8'hF2);
        cyc(1'b1, 8'hF3, 1'b0, 1'b0, 1'b1);
        check_val("sim_rd_count", {27'd0, rd_count}, 32'd5);
        check_val("sim_pkt_done", {31'd0, pkt_done}, 32'd1);
        pop_check("sim_rd0", 8'hE2);
        pop_check("sim_rd1", 8'hE3);
        pop_check("sim_rd2", 8'hF1);
        pop_check("sim_rd3", 8'hF2);
        pop_check("sim_rd4", 8'hF3);
        check_val("sim_empty", {31'd0, empty}, 32'd1);

        // Reset in the middle of a packet
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h02);
        send_byte(1'b0, 8'h03);
        send_byte(1'b1, 8'h04);
        send_byte(1'b1, 8'h05);
        n_rst = 1'b0;
        #1;
        check_val("midrst_rd_count", {27'd0, rd_count}, 32'd0);
        check_val("midrst_empty", {31'd0, empty}, 32'd1);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        send_byte(1'b0, 8'h71);
        send_byte(1'b0, 8'h72);
        send_byte(1'b0, 8'h73);
        check_val("midrst_pkt_done", {31'd0, pkt_done}, 32'd1);
        check_val("midrst_new_rd_count", {27'd0, rd_count}, 32'd3);
        pop_check("midrst_rd0", 8'h71);
        pop_check("midrst_rd1", 8'h72);
        pop_check("midrst_rd2", 8'h73);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/usb_rx_packet_fifo.md
Name: usb_rx_packet_fifo

Overview:
- Sits directly downstream of the USB receive top level.
- Consumes the decoded byte stream (rx_data / write_enable / rcv_error) and stores each packet speculatively.
- Commits a packet only once it is complete and error-free; on rcv_error it rolls the packet back.
- Presents committed bytes to the miner-side logic through a show-ahead read port.

Parameters:
- DEPTH, 16, byte storage entries; power of two, minimum 8.
- PKT0_LEN, 3, data bytes per packet when packet_type=0 (sync already stripped upstream).
- PKT1_LEN, 7, data bytes per packet when packet_type=1.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- packet_type  in  1  selects the expected length of the incoming packet.
- rx_data  in  8  received byte, valid when write_enable=1.
- write_enable  in  1  one-cycle strobe per received byte.
- rcv_error  in  1  upstream error flag; the current packet is invalid.
- read_enable  in  1  consumer pops one byte.
- read_data  out  8  byte at the committed head (show-ahead).
- empty  out  1  no committed bytes are available.
- full  out  1  storage holds DEPTH bytes (committed plus speculative).
- rd_count  out  $clog2(DEPTH)+1  number of committed unread bytes.
- pkt_done  out  1  one-cycle pulse when a packet commits.
- overflow  out  1  one-cycle pulse when a packet is dropped for lack of space.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (n_rst).
- Pointers are $clog2(DEPTH)+1 bits with the extra wrap bit:
  - rp: read pointer.
  - cw: committed write pointer.
  - sw: speculative write pointer.
- Storage is a register array with no reset.
- Reset values: rp=cw=sw=0, byte_cnt=0, state=IDLE, empty=1, full=0, rd_count=0, pkt_done=0, overflow=0, read_data=mem[0] (undefined content).
- Derived outputs: empty=(rp==cw); full=((sw-rp)==DEPTH); rd_count=cw-rp. All are combinational from the pointers.
- read_data=mem[rp[AW-1:0]] combinationally. On read_enable & !empty, rp advances by 1 at the next edge. read_enable while empty is ignored.
- Target length LEN is latched from packet_type on the first byte of each packet: PKT0_LEN if 0, else PKT1_LEN.
- FSM states:
  - IDLE: waiting for the first byte of a packet.
  - COLLECT: storing bytes of the current packet.
  - DROP: discarding the rest of a packet that did not fit.
- IDLE, on write_enable:
  - If !full: store at sw, sw+1, byte_cnt=1, latch LEN, go to COLLECT.
  - If full: overflow pulse, byte_cnt=1, latch LEN, go to DROP.
  - Special case LEN=1: commit immediately and stay in IDLE.
- COLLECT, on write_enable:
  - If full: overflow pulse, sw<=cw (rollback), go to DROP.
  - Else store the byte, sw+1, byte_cnt+1.
  - When this byte makes byte_cnt==LEN: cw<=sw+1, pkt_done pulse, byte_cnt=0, go to IDLE.
- DROP:
  - On write_enable, byte_cnt+1; nothing is stored.
  - When byte_cnt reaches LEN: byte_cnt=0, go to IDLE.
- rcv_error in any state:
  - sw<=cw, byte_cnt=0, go to IDLE.
  - A write_enable in the same cycle is discarded (error wins).
  - No pkt_done and no overflow pulse.
- Simultaneous read and write/commit in one cycle are both honoured. full is evaluated on pre-edge pointers, so a read in the same cycle does not free space for that cycle's write.
- Wrap-around: pointers wrap modulo 2*DEPTH. Address = pointer[AW-1:0].
- pkt_done and overflow are registered: they are high for exactly one cycle after the triggering edge.
- Reset mid-packet: all pointers clear and any partial or committed data is lost.

Test Plan:
- Reset: n_rst=0 then 1 -> empty=1, full=0, rd_count=0, pkt_done=0, overflow=0.
- packet_type=0, bytes 0xB4,0xA8,0xF7 -> pkt_done pulses once after the 3rd byte, rd_count=3. Then 3 read_enable pops -> read_data 0xB4, 0xA8, 0xF7 in order, then empty=1.
- packet_type=1, 4 bytes, then rcv_error -> rd_count stays 0 and sw rolls back. A following clean 7-byte packet 0xC3,0x00,0x80,0x40,0xC0,0xF7,0x5E -> rd_count=7, and data reads back in order.
- Fill with two type-1 packets (14 committed), then a type-0 packet -> 2 bytes stored, 3rd arrives full -> overflow pulses. Rollback leaves rd_count=14, no pkt_done, state returns to IDLE after the 3rd byte.
- Wrap: repeatedly commit and drain 3-byte packets 10 times (30 bytes, crossing 16 twice) -> data integrity holds, empty/full correct at every step.
- Simultaneous: rcv_error with write_enable on the 3rd byte of a type-0 packet -> no commit, rd_count unchanged. Also, read_enable on the same cycle as a commit -> rd_count = old+3-1.
